// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one 16-bit GCD engine between NREQ requesters.
// One job in flight at a time; results return to the requester that issued the job.
module gcd_scheduler #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 20
) (
  input  logic                iClk,
  input  logic                iRstn,
  input  logic [NREQ-1:0]     iReqValid,
  input  logic [NREQ*16-1:0]  iReqA,
  input  logic [NREQ*16-1:0]  iReqB,
  output logic [NREQ-1:0]     oReqReady,
  output logic [NREQ-1:0]     oRspValid,
  output logic [15:0]         oRspC,
  input  logic [NREQ-1:0]     iRspReady,
  output logic                oGcdValid,
  output logic [15:0]         oGcdA,
  output logic [15:0]         oGcdB,
  input  logic                iGcdReady,
  input  logic [15:0]         iGcdC,
  output logic                oBusy,
  output logic [CNT_W-1:0]    oLastCycles
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   next_rr;
  logic             grant_any;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [CNT_W-1:0] cnt;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (iReqValid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign next_rr   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign req_a     = iReqA[{grant_id, 4'b0000} +: 16];
  assign req_b     = iReqB[{grant_id, 4'b0000} +: 16];
  assign oReqReady = (state == IDLE && iRstn && grant_any) ? (NREQ'(1) << grant_id) : '0;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id          <= '0;
      cnt         <= '0;
      oRspValid   <= '0;
      oRspC       <= '0;
      oGcdValid   <= 1'b0;
      oGcdA       <= '0;
      oGcdB       <= '0;
      oBusy       <= 1'b0;
      oLastCycles <= '0;
    end else begin
      oGcdValid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            id     <= grant_id;
            rr_ptr <= next_rr;
            oBusy  <= 1'b1;
            // A==0 would never terminate in the engine; gcd(0,B)=B directly.
            if (req_a == 16'd0) begin
              oRspC     <= req_b;
              oRspValid <= NREQ'(1) << grant_id;
              state     <= RESP;
            end else begin
              oGcdA     <= req_a;
              oGcdB     <= req_b;
              oGcdValid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        // Engine ready may still hold the previous job's level here.
        SETTLE: state <= WAIT;
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (iGcdReady) begin
            oRspC       <= iGcdC;
            oLastCycles <= cnt;
            oRspValid   <= NREQ'(1) << id;
            state       <= RESP;
          end
        end
        RESP: begin
          if (iRspReady[id]) begin
            oRspValid <= '0;
            oBusy     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
